// File: rtl/pixel_timing_pkg.sv
// Shared raster timing constants and the wrap-counter next-value helper.
// Holds the 720p default timing and a 1080p alternate preset.
package pixel_timing_pkg;

  // 1280x720 @ 74.25 MHz (default preset)
  localparam int unsigned X_ACTIVE_720P  = 1280;
  localparam int unsigned X_TOTAL_720P   = 1650;
  localparam int unsigned Y_ACTIVE_720P  = 720;
  localparam int unsigned Y_TOTAL_720P   = 750;
  localparam int unsigned HS_START_720P  = 1390;
  localparam int unsigned HS_END_720P    = 1430;
  localparam int unsigned VS_START_720P  = 725;
  localparam int unsigned VS_END_720P    = 730;
  localparam bit          HS_POL_720P    = 1'b1;
  localparam bit          VS_POL_720P    = 1'b1;

  // 1920x1080 @ 148.5 MHz (alternate preset)
  localparam int unsigned X_ACTIVE_1080P = 1920;
  localparam int unsigned X_TOTAL_1080P  = 2200;
  localparam int unsigned Y_ACTIVE_1080P = 1080;
  localparam int unsigned Y_TOTAL_1080P  = 1125;
  localparam int unsigned HS_START_1080P = 2008;
  localparam int unsigned HS_END_1080P   = 2052;
  localparam int unsigned VS_START_1080P = 1084;
  localparam int unsigned VS_END_1080P   = 1089;
  localparam bit          HS_POL_1080P   = 1'b1;
  localparam bit          VS_POL_1080P   = 1'b1;

  // Next value of a 0..max_val counter. Wraps on >= so a counter can never
  // present an out-of-range value, even at non-power-of-2 totals.
  function automatic int unsigned wrap_next(input int unsigned cnt,
                                            input int unsigned max_val,
                                            input logic        clear,
                                            input logic        inc);
    if (clear) begin
      return 0;
    end
    if (inc) begin
      return (cnt >= max_val) ? 0 : cnt + 1;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/pixel_xy_counter_wrap_counter.sv
// wrap_counter: modulo-(MAX+1) counter with synchronous clear and step
// enable. atMax flags the last value so a cascaded counter can step on it.
module wrap_counter
  import pixel_timing_pkg::*;
#(
  parameter int unsigned MAX = 1,
  parameter int unsigned W   = (MAX < 1) ? 1 : $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         atMax
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear beats inc, wrap to zero after MAX.
  always_comb begin
    cnt_d = W'(wrap_next(32'(cnt_q), MAX, clear, inc));
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt   = cnt_q;
  assign atMax = (32'(cnt_q) == MAX);

endmodule

// File: rtl/pixel_xy_counter.sv
// pixel_xy_counter: raster (x,y) position generator with registered
// active-region and line/frame boundary flags.
// Optional hsync/vsync outputs are built when PIXEL_XY_SYNC_EN is defined.
module pixel_xy_counter
  import pixel_timing_pkg::*;
#(
  parameter int unsigned X_ACTIVE = X_ACTIVE_720P,
  parameter int unsigned X_TOTAL  = X_TOTAL_720P,
  parameter int unsigned Y_ACTIVE = Y_ACTIVE_720P,
  parameter int unsigned Y_TOTAL  = Y_TOTAL_720P,
  parameter int unsigned X_W      = $clog2(X_TOTAL),
  parameter int unsigned Y_W      = $clog2(Y_TOTAL)
`ifdef PIXEL_XY_SYNC_EN
  ,
  parameter int unsigned HS_START = HS_START_720P,
  parameter int unsigned HS_END   = HS_END_720P,
  parameter int unsigned VS_START = VS_START_720P,
  parameter int unsigned VS_END   = VS_END_720P,
  parameter bit          HS_POL   = HS_POL_720P,
  parameter bit          VS_POL   = VS_POL_720P
`endif
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pixelInc,
  input  logic           restart,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           lineStart,
  output logic           lineEnd,
  output logic           frameStart,
  output logic           frameEnd
`ifdef PIXEL_XY_SYNC_EN
  ,
  output logic           hsync,
  output logic           vsync
`endif
);

  if (X_ACTIVE > X_TOTAL || Y_ACTIVE > Y_TOTAL || X_TOTAL < 2 || Y_TOTAL < 2) begin : g_param_err
    $error("pixel_xy_counter: need X_ACTIVE<=X_TOTAL, Y_ACTIVE<=Y_TOTAL, totals>=2");
  end

  logic           x_at_max;
  logic           y_at_max;
  logic           y_inc;
  logic [X_W-1:0] x_d;
  logic [Y_W-1:0] y_d;

  logic active_q;
  logic line_start_q;
  logic line_end_q;
  logic frame_start_q;
  logic frame_end_q;

  // y only steps on the pixel that closes a line.
  assign y_inc = pixelInc & x_at_max;

  wrap_counter #(.MAX(X_TOTAL - 1), .W(X_W)) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .inc   (pixelInc),
    .cnt   (x),
    .atMax (x_at_max)
  );

  wrap_counter #(.MAX(Y_TOTAL - 1), .W(Y_W)) u_y_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (restart),
    .inc   (y_inc),
    .cnt   (y),
    .atMax (y_at_max)
  );

  // Position the counters will present next cycle; flags decode this so
  // they are registered in lockstep with x/y rather than lagging a cycle.
  always_comb begin
    x_d = x;
    y_d = y;
    if (restart) begin
      x_d = '0;
      y_d = '0;
    end else if (pixelInc) begin
      x_d = x_at_max ? '0 : x + X_W'(1);
      if (x_at_max) begin
        y_d = y_at_max ? '0 : y + Y_W'(1);
      end
    end
  end

  // Boundary/active flag registers, aligned with the presented (x,y).
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q      <= 1'b1;
      line_start_q  <= 1'b1;
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b1;
      frame_end_q   <= 1'b0;
    end else begin
      active_q      <= (32'(x_d) < X_ACTIVE) && (32'(y_d) < Y_ACTIVE);
      line_start_q  <= (x_d == '0);
      line_end_q    <= (32'(x_d) == X_TOTAL - 1);
      frame_start_q <= (x_d == '0) && (y_d == '0);
      frame_end_q   <= (32'(x_d) == X_TOTAL - 1) && (32'(y_d) == Y_TOTAL - 1);
    end
  end

  assign active     = active_q;
  assign lineStart  = line_start_q;
  assign lineEnd    = line_end_q;
  assign frameStart = frame_start_q;
  assign frameEnd   = frame_end_q;

`ifdef PIXEL_XY_SYNC_EN
  logic hsync_q;
  logic vsync_q;

  // Sync pulse registers; idle at the inactive level after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
    end else begin
      hsync_q <= ((32'(x_d) >= HS_START) && (32'(x_d) < HS_END)) ? HS_POL : ~HS_POL;
      vsync_q <= ((32'(y_d) >= VS_START) && (32'(y_d) < VS_END)) ? VS_POL : ~VS_POL;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

endmodule

// File: tb/tb_pixel_xy_counter.sv
// Scoreboard bench for pixel_xy_counter on a 6x3 raster (4x2 active).
// Driver pushes the expected post-edge state; a monitor pops and compares.
module tb_pixel_xy_counter;

  localparam int XA = 4;
  localparam int XT = 6;
  localparam int YA = 2;
  localparam int YT = 3;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic       pixelInc = 1'b0;
  logic       restart  = 1'b0;
  logic [2:0] x;
  logic [1:0] y;
  logic       active, lineStart, lineEnd, frameStart, frameEnd;
  logic       hsync, vsync;

  always #5 clk = ~clk;

  pixel_xy_counter #(
    .X_ACTIVE (XA),
    .X_TOTAL  (XT),
    .Y_ACTIVE (YA),
    .Y_TOTAL  (YT)
`ifdef PIXEL_XY_SYNC_EN
    ,
    .HS_START (4),
    .HS_END   (5),
    .VS_START (2),
    .VS_END   (3),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pixelInc   (pixelInc),
    .restart    (restart),
    .x          (x),
    .y          (y),
    .active     (active),
    .lineStart  (lineStart),
    .lineEnd    (lineEnd),
    .frameStart (frameStart),
    .frameEnd   (frameEnd)
`ifdef PIXEL_XY_SYNC_EN
    ,
    .hsync      (hsync),
    .vsync      (vsync)
`endif
  );

`ifndef PIXEL_XY_SYNC_EN
  assign hsync = 1'b0;
  assign vsync = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] x;
    logic [1:0] y;
    logic       act;
    logic       ls;
    logic       le;
    logic       fs;
    logic       fe;
    logic       hs;
    logic       vs;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;
  int    mx = 0;
  int    my = 0;

  // Expected outputs for a position, straight from the flag definitions.
  function automatic obs_t expect_at(input int ex, input int ey);
    obs_t e;
    e.x   = 3'(ex);
    e.y   = 2'(ey);
    e.act = (ex < XA) && (ey < YA);
    e.ls  = (ex == 0);
    e.le  = (ex == XT - 1);
    e.fs  = (ex == 0) && (ey == 0);
    e.fe  = (ex == XT - 1) && (ey == YT - 1);
`ifdef PIXEL_XY_SYNC_EN
    e.hs  = (ex == 4);
    e.vs  = (ey == 2);
`else
    e.hs  = 1'b0;
    e.vs  = 1'b0;
`endif
    return e;
  endfunction

  // One clock of stimulus. hx/hy >= 0 give a hand-computed expected
  // position; otherwise the raster model advances.
  task automatic step(input logic r, input logic rs, input logic inc,
                      input string tag, input int hx, input int hy);
    reset    = r;
    restart  = rs;
    pixelInc = inc;
    @(posedge clk);
    #1;
    if (hx >= 0) begin
      mx = hx;
      my = hy;
    end else if (r || rs) begin
      mx = 0;
      my = 0;
    end else if (inc) begin
      if (mx == XT - 1) begin
        mx = 0;
        my = (my == YT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
    end
    exp_q.push_back(expect_at(mx, my));
    tag_q.push_back(tag);
  endtask

  obs_t  mon_e;
  obs_t  mon_a;
  string mon_t;

  // Monitor: compare every presented state against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        mon_a = {x, y, active, lineStart, lineEnd, frameStart, frameEnd, hsync, vsync};
        checks++;
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL %s: got x=%0d y=%0d act/ls/le/fs/fe/hs/vs=%b, required x=%0d y=%0d act/ls/le/fs/fe/hs/vs=%b",
                   mon_t, mon_a.x, mon_a.y, mon_a[6:0], mon_e.x, mon_e.y, mon_e[6:0]);
        end else begin
          $display("ok   %s: x=%0d y=%0d act/ls/le/fs/fe/hs/vs=%b",
                   mon_t, mon_a.x, mon_a.y, mon_a[6:0]);
        end
      end
    end
  end

  initial begin
    // Reset for two cycles.
    step(1'b1, 1'b0, 1'b0, "reset0", 0, 0);
    step(1'b1, 1'b0, 1'b0, "reset1", 0, 0);

    // 18 back-to-back steps: one full frame, ending back at the origin.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, "sweep", -1, -1);
    step(1'b0, 1'b0, 1'b1, "sweep_end", 0, 0);

    // pixelInc 1,0,0,1.
    step(1'b0, 1'b0, 1'b1, "tog_inc", 1, 0);
    step(1'b0, 1'b0, 1'b0, "tog_hold0", 1, 0);
    step(1'b0, 1'b0, 1'b0, "tog_hold1", 1, 0);
    step(1'b0, 1'b0, 1'b1, "tog_inc2", 2, 0);

    // Walk to (3,1), then restart with pixelInc high.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, "to_3_1", -1, -1);
    step(1'b0, 1'b0, 1'b1, "at_3_1", 3, 1);
    step(1'b0, 1'b1, 1'b1, "restart_inc", 0, 0);

    // Restart mid-line with pixelInc low.
    step(1'b0, 1'b0, 1'b1, "pre_rs0", 1, 0);
    step(1'b0, 1'b0, 1'b1, "pre_rs1", 2, 0);
    step(1'b0, 1'b1, 1'b0, "restart_hold", 0, 0);

    // Walk to (5,2), then reset with pixelInc high: no wrap.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 1'b1, "to_5_2", -1, -1);
    step(1'b0, 1'b0, 1'b1, "at_5_2", 5, 2);
    step(1'b1, 1'b0, 1'b1, "reset_at_end", 0, 0);
    step(1'b0, 1'b0, 1'b1, "post_reset", 1, 0);
    step(1'b0, 1'b0, 1'b0, "post_hold", 1, 0);

    // End of a line with hold, then line wrap.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, "to_5_0", -1, -1);
    step(1'b0, 1'b0, 1'b1, "at_5_0", 5, 0);
    step(1'b0, 1'b0, 1'b0, "hold_5_0", 5, 0);
    step(1'b0, 1'b0, 1'b1, "line_wrap", 0, 1);

    // Reset and restart together.
    step(1'b1, 1'b1, 1'b1, "reset_restart", 0, 0);
    step(1'b0, 1'b0, 1'b0, "idle", 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending, required 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_xy_counter.md
Name: pixel_xy_counter

Overview:
- Parametrised raster position generator; successor to the single-axis pixel counter at the head of GPU pipe 0.
- Counts x across a full line (active + blanking) and y across a full frame, advancing on a single-cycle pixelInc enable in the pixel clock domain.
- Emits active-region and line/frame boundary flags (optionally hsync/vsync) for downstream layer-fetch and video-timing stages.

Parameters:
- X_ACTIVE, 1280, visible pixels per line.
- X_TOTAL, 1650, total pixel slots per line incl. blanking; must be >= X_ACTIVE and >= 2.
- Y_ACTIVE, 720, visible lines per frame.
- Y_TOTAL, 750, total lines per frame incl. blanking; must be >= Y_ACTIVE and >= 2.
- X_W, $clog2(X_TOTAL), x output width (derived; do not override).
- Y_W, $clog2(Y_TOTAL), y output width (derived; do not override).

Ports:
- clk  in  1  pixel-domain clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pixelInc  in  1  advance enable; one pixel step per cycle while high.
- restart  in  1  synchronous realign to (0,0), e.g. to lock to an external vsync.
- x  out  X_W  current column, 0..X_TOTAL-1.
- y  out  Y_W  current line, 0..Y_TOTAL-1.
- active  out  1  high when x < X_ACTIVE and y < Y_ACTIVE.
- lineStart  out  1  x == 0.
- lineEnd  out  1  x == X_TOTAL-1.
- frameStart  out  1  x == 0 and y == 0.
- frameEnd  out  1  x == X_TOTAL-1 and y == Y_TOTAL-1.

Behaviour:
- All outputs are registered. Flags are registered together with x/y and always describe the currently presented (x,y); they are never combinational decodes of inputs.
- Reset values: x=0, y=0, active=1, lineStart=1, lineEnd=0, frameStart=1, frameEnd=0.
- Priority each cycle: reset > restart > pixelInc > hold.
- restart=1: next state is (0,0) with flags as at reset, regardless of pixelInc.
- pixelInc=1:
  - x<X_TOTAL-1: x+1, y unchanged.
  - x==X_TOTAL-1: x=0; y+1 if y<Y_TOTAL-1, else y=0 (frame wrap).
- Latency: 1 cycle from pixelInc sample to updated x/y/flags.
- pixelInc=0: all outputs hold.
- Back-to-back pixelInc is legal and gives one step per cycle.
- Comparisons use full-width unsigned arithmetic. Counters must never present values >= X_TOTAL / Y_TOTAL, including at non-power-of-2 totals.
- Reset or restart asserted mid-line or mid-frame discards the current position immediately; no partial line completes.
- Elaboration check: $error if X_ACTIVE > X_TOTAL, Y_ACTIVE > Y_TOTAL, or either total < 2.

Optional Feature:
- Macro: PIXEL_XY_SYNC_EN.
- Defined:
  - Adds parameters HS_START, HS_END, VS_START, VS_END, HS_POL, VS_POL.
  - Adds registered outputs hsync and vsync.
  - hsync is asserted (level = HS_POL) when HS_START <= x < HS_END.
  - vsync is asserted (level = VS_POL) when VS_START <= y < VS_END.
  - Both update in the same cycle as x/y. Reset value of each is its inactive level (!POL).
- Undefined: these ports and parameters do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package pixel_timing_pkg holds:
  - Default 720p timing constants (X_ACTIVE/X_TOTAL/Y_ACTIVE/Y_TOTAL and sync positions).
  - Alternate preset constants for 1080p.
- Sub-module wrap_counter, instanced twice: parameter MAX; inputs clk, reset, clear, inc; outputs cnt and atMax.
  - x instance: inc = pixelInc.
  - y instance: inc = pixelInc & x atMax.
  - Top level registers the flags.

Test Plan (X_ACTIVE=4, X_TOTAL=6, Y_ACTIVE=2, Y_TOTAL=3 unless noted):
- reset high for 2 cycles -> x=0, y=0, active=1, lineStart=1, frameStart=1, lineEnd=0, frameEnd=0.
- pixelInc held high for 18 cycles from reset:
  - x sequence 0..5 repeating; y steps 0,1,2 then back to 0.
  - active low exactly for x in 4..5 or y=2.
  - frameEnd high at (5,2); back at (0,0) after cycle 18.
- pixelInc toggled 1,0,0,1 -> x advances 0,1,1,1,2; flags stable while held.
- restart at (3,1) with pixelInc=1 in the same cycle -> next cycle (0,0) and frameStart=1.
- reset at (5,2) with pixelInc=1 in the same cycle -> (0,0), reset values; no wrap artefacts.
- Defaults (1280/1650/720/750), pixelInc continuous for 1650*750 cycles:
  - x never exceeds 1649, y never exceeds 749.
  - Exactly one frameStart pulse per frame.
  - With PIXEL_XY_SYNC_EN (HS 1390..1430, VS 725..730, POL=1): hsync high for 40 cycles per line, vsync high for 5 lines.
